// File: rtl/ins_loader.sv
// ins_loader: program loader in front of the MIPS core's instruction-write port.
// Takes a byte stream (valid/ready), reads a 16-bit big-endian word count N,
// then assembles N big-endian 32-bit words and writes each one to instruction
// memory at consecutive word addresses. The core is held in reset until the
// whole program has been written.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   start             one-cycle pulse; begins a load from IDLE, DONE or ERR
//   byte_in/valid     stream byte and its valid flag
//   byte_ready        loader accepts byte_in this cycle
//   W_Ins/WE/W_Addr   registered instruction-memory write (WE one cycle per word)
//   CPU_RST           reset to the core; low only in DONE
//   busy/done/err     load in progress / last load ok / last load rejected
module ins_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [31:0]       W_Ins,
    output logic              WE,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              CPU_RST,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;

    // Largest accepted word count: the full instruction memory.
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t      state, state_nx;
    logic [15:0] len;
    logic [16:0] idx;       // one bit wider than N so index+1 can reach N=65536-range counts
    logic [16:0] idx_inc;
    logic [1:0]  bcnt;
    logic [23:0] word;      // first three bytes of the word in flight
    logic [15:0] n_now;     // word count as it completes in LEN_LO
    logic        accept;

    assign n_now   = {len[15:8], byte_in};
    assign idx_inc = idx + 17'd1;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
        busy       = byte_ready || (state == WRITE);
        done       = (state == DONE);
        err        = (state == ERR);
        CPU_RST    = (state != DONE);
        accept     = byte_valid && byte_ready;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = LEN_HI;
            LEN_HI:          if (accept) state_nx = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (n_now == 16'd0)            state_nx = DONE;
                    else if ({1'b0, n_now} > CAP)  state_nx = ERR;
                    else                           state_nx = DATA;
                end
            end
            DATA:  if (accept && bcnt == 2'd3) state_nx = WRITE;
            WRITE: state_nx = (idx_inc == {1'b0, len}) ? DONE : DATA;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath. The write is registered on the 4th accepted byte so that
    // WE/W_Ins/W_Addr are valid exactly while the FSM sits in WRITE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            len    <= '0;
            idx    <= '0;
            bcnt   <= '0;
            word   <= '0;
            WE     <= 1'b0;
            W_Ins  <= '0;
            W_Addr <= '0;
        end else begin
            WE <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        idx  <= '0;
                        bcnt <= '0;
                    end
                end
                LEN_HI: if (accept) len[15:8] <= byte_in;
                LEN_LO: if (accept) len[7:0]  <= byte_in;
                DATA: begin
                    if (accept) begin
                        word <= {word[15:0], byte_in};
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            WE     <= 1'b1;
                            W_Ins  <= {word, byte_in};
                            W_Addr <= idx[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    idx  <= idx_inc;
                    bcnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
